// File: rtl/tcdm_g_pkg.sv
// Shared types, width helpers and the protocol-check macro for the grouped TCDM arbiter.

// Flags a protocol violation in simulation without stopping the run.
`define TCDM_G_PROTO_ASSERT(clk_, rst_, cond_, msg_) \
  assert property (@(posedge clk_) disable iff (rst_) (cond_)) \
    else $warning(msg_)

package tcdm_g_pkg;

  // Container for a requester ID as stored in the owner FIFO.
  localparam int unsigned OWNER_ID_MAX_W = 8;
  typedef logic [OWNER_ID_MAX_W-1:0] owner_id_t;

  // Index width for n items; a single item still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter able to hold the value depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tcdm_g_rr_port.sv
// One grouped port: round-robin arbiter over NREQ requesters, plus an
// in-order owner FIFO that routes each TCDM response back to its issuer.

module tcdm_g_rr_port
  import tcdm_g_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WDATA_W    = 32,
  parameter int unsigned BE_W       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_slave,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      add_slave,
  input  logic [NREQ-1:0]                      wen_slave,
  input  logic [NREQ-1:0][WDATA_W-1:0]         wdata_slave,
  input  logic [NREQ-1:0][BE_W-1:0]            be_slave,
  output logic [NREQ-1:0]                      gnt_slave,
  output logic [NREQ-1:0]                      r_valid_slave,
  output logic                                 req_master,
  output logic [ADDR_WIDTH-1:0]                add_master,
  output logic                                 wen_master,
  output logic [WDATA_W-1:0]                   wdata_master,
  output logic [BE_W-1:0]                      be_master,
  input  logic                                 gnt_master,
  input  logic                                 r_valid_master
);

  localparam int unsigned ID_W  = id_width(NREQ);
  localparam int unsigned PTR_W = id_width(MAX_OUTST);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTST);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(MAX_OUTST);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [NREQ-1:0]  mask;
  logic             hit;
  logic             any_req;
  logic             full;
  logic             empty;
  logic             hs;
  logic             pop;

  owner_id_t        fifo_q [MAX_OUTST];
  owner_id_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign head  = fifo_q[rd_ptr];

  // Thermometer mask of requesters at or above rr_ptr; equality-only so the
  // upper pass stays free of range comparisons against the pointer.
  always_comb begin
    hit  = 1'b0;
    mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rr_ptr == ID_W'(i)) hit = 1'b1;
      mask[i] = hit;
    end
  end

  // Pick the first requester from rr_ptr upward, wrapping to the bottom.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_slave[i] && mask[i]) begin
        any_req = 1'b1;
        winner  = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_slave[i]) begin
        any_req = 1'b1;
        winner  = ID_W'(i);
      end
    end
  end

  // Master-side request/fields and per-requester grant/response decode.
  always_comb begin
    req_master    = ~rst & any_req & ~full;
    hs            = req_master & gnt_master;
    pop           = ~rst & r_valid_master & ~empty;
    gnt_slave     = '0;
    r_valid_slave = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_slave[i]     = hs & (winner == ID_W'(i));
      r_valid_slave[i] = pop & (head == owner_id_t'(i));
    end
    add_master   = add_slave[winner];
    wen_master   = wen_slave[winner];
    wdata_master = wdata_slave[winner];
    be_master    = be_slave[winner];
  end

  // Round-robin pointer and owner FIFO; push and pop in one cycle cancel in count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned k = 0; k < MAX_OUTST; k++) fifo_q[k] <= '0;
    end else begin
      if (hs) begin
        fifo_q[wr_ptr] <= owner_id_t'(winner);
        wr_ptr         <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
        rr_ptr         <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (hs && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !hs) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  `TCDM_G_PROTO_ASSERT(clk, rst, !(r_valid_master && empty),
                       "tcdm_g_rr_port: r_valid_master with no outstanding request");

endmodule

// File: rtl/tcdm_g_arbiter.sv
// Shares NPX grouped TCDM master ports between NREQ grouped requesters.
// Each port is arbitrated independently by its own tcdm_g_rr_port.

module tcdm_g_arbiter
  import tcdm_g_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE       = 1,
  parameter int unsigned NPX        = 4,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NREQ-1:0][NPX-1:0]                        req_slave,
  input  logic [NREQ-1:0][NPX-1:0][ADDR_WIDTH-1:0]        add_slave,
  input  logic [NREQ-1:0][NPX-1:0]                        wen_slave,
  input  logic [NREQ-1:0][NPX-1:0][SIZE*DATA_WIDTH-1:0]   wdata_slave,
  input  logic [NREQ-1:0][NPX-1:0][SIZE*BE_WIDTH-1:0]     be_slave,
  output logic [NREQ-1:0][NPX-1:0]                        gnt_slave,
  output logic [NREQ-1:0][NPX-1:0]                        r_valid_slave,
  output logic [NREQ-1:0][NPX-1:0][SIZE*DATA_WIDTH-1:0]   r_rdata_slave,
  output logic [NPX-1:0]                                  req_master,
  output logic [NPX-1:0][ADDR_WIDTH-1:0]                  add_master,
  output logic [NPX-1:0]                                  wen_master,
  output logic [NPX-1:0][SIZE*DATA_WIDTH-1:0]             wdata_master,
  output logic [NPX-1:0][SIZE*BE_WIDTH-1:0]               be_master,
  input  logic [NPX-1:0]                                  gnt_master,
  input  logic [NPX-1:0]                                  r_valid_master,
  input  logic [NPX-1:0][SIZE*DATA_WIDTH-1:0]             r_rdata_master
);

  localparam int unsigned WW = SIZE * DATA_WIDTH;
  localparam int unsigned BW = SIZE * BE_WIDTH;

  for (genvar j = 0; j < NPX; j++) begin : g_port
    logic [NREQ-1:0]                 req_p;
    logic [NREQ-1:0]                 wen_p;
    logic [NREQ-1:0]                 gnt_p;
    logic [NREQ-1:0]                 rv_p;
    logic [NREQ-1:0][ADDR_WIDTH-1:0] add_p;
    logic [NREQ-1:0][WW-1:0]         wdata_p;
    logic [NREQ-1:0][BW-1:0]         be_p;

    // Regroup the requester-major buses into this port's per-requester view.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign req_p[i]             = req_slave[i][j];
      assign wen_p[i]             = wen_slave[i][j];
      assign add_p[i]             = add_slave[i][j];
      assign wdata_p[i]           = wdata_slave[i][j];
      assign be_p[i]              = be_slave[i][j];
      assign gnt_slave[i][j]      = gnt_p[i];
      assign r_valid_slave[i][j]  = rv_p[i];
      assign r_rdata_slave[i][j]  = r_rdata_master[j];
    end

    tcdm_g_rr_port #(
      .NREQ       (NREQ),
      .MAX_OUTST  (MAX_OUTST),
      .ADDR_WIDTH (ADDR_WIDTH),
      .WDATA_W    (WW),
      .BE_W       (BW)
    ) u_port (
      .clk            (clk),
      .rst            (rst),
      .req_slave      (req_p),
      .add_slave      (add_p),
      .wen_slave      (wen_p),
      .wdata_slave    (wdata_p),
      .be_slave       (be_p),
      .gnt_slave      (gnt_p),
      .r_valid_slave  (rv_p),
      .req_master     (req_master[j]),
      .add_master     (add_master[j]),
      .wen_master     (wen_master[j]),
      .wdata_master   (wdata_master[j]),
      .be_master      (be_master[j]),
      .gnt_master     (gnt_master[j]),
      .r_valid_master (r_valid_master[j])
    );
  end

endmodule

// File: tb/tb_tcdm_g_arbiter.sv
// Self-checking bench for tcdm_g_arbiter with a queue-based reference model.

module tb_tcdm_g_arbiter;

  localparam int NREQ = 2;
  localparam int NPX  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SZ   = 2;
  localparam int MO   = 2;
  localparam int WW   = SZ * DW;
  localparam int BW   = SZ * (DW / 8);

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0][NPX-1:0]         req_slave;
  logic [NREQ-1:0][NPX-1:0][AW-1:0] add_slave;
  logic [NREQ-1:0][NPX-1:0]         wen_slave;
  logic [NREQ-1:0][NPX-1:0][WW-1:0] wdata_slave;
  logic [NREQ-1:0][NPX-1:0][BW-1:0] be_slave;
  logic [NREQ-1:0][NPX-1:0]         gnt_slave;
  logic [NREQ-1:0][NPX-1:0]         r_valid_slave;
  logic [NREQ-1:0][NPX-1:0][WW-1:0] r_rdata_slave;
  logic [NPX-1:0]                   req_master;
  logic [NPX-1:0][AW-1:0]           add_master;
  logic [NPX-1:0]                   wen_master;
  logic [NPX-1:0][WW-1:0]           wdata_master;
  logic [NPX-1:0][BW-1:0]           be_master;
  logic [NPX-1:0]                   gnt_master;
  logic [NPX-1:0]                   r_valid_master;
  logic [NPX-1:0][WW-1:0]           r_rdata_master;

  tcdm_g_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (DW / 8),
    .SIZE       (SZ),
    .NPX        (NPX),
    .NREQ       (NREQ),
    .MAX_OUTST  (MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_slave      (req_slave),
    .add_slave      (add_slave),
    .wen_slave      (wen_slave),
    .wdata_slave    (wdata_slave),
    .be_slave       (be_slave),
    .gnt_slave      (gnt_slave),
    .r_valid_slave  (r_valid_slave),
    .r_rdata_slave  (r_rdata_slave),
    .req_master     (req_master),
    .add_master     (add_master),
    .wen_master     (wen_master),
    .wdata_master   (wdata_master),
    .be_master      (be_master),
    .gnt_master     (gnt_master),
    .r_valid_master (r_valid_master),
    .r_rdata_master (r_rdata_master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: next-preferred requester and outstanding owners per port.
  int rr_m [NPX];
  int q_m  [NPX][$];
  logic [NPX-1:0]           exp_req;
  logic [NREQ-1:0][NPX-1:0] exp_gnt;
  logic [NREQ-1:0][NPX-1:0] exp_rv;
  int                       exp_win [NPX];

  task automatic model_eval();
    int idx;
    exp_req = '0;
    exp_gnt = '0;
    exp_rv  = '0;
    for (int j = 0; j < NPX; j++) begin
      exp_win[j] = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr_m[j] + k) % NREQ;
        if (exp_win[j] < 0 && req_slave[idx][j]) exp_win[j] = idx;
      end
      if (!rst && exp_win[j] >= 0 && q_m[j].size() < MO) begin
        exp_req[j] = 1'b1;
        if (gnt_master[j]) exp_gnt[exp_win[j]][j] = 1'b1;
      end
      if (!rst && r_valid_master[j] && q_m[j].size() > 0)
        exp_rv[q_m[j][0]][j] = 1'b1;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    for (int j = 0; j < NPX; j++) begin
      if (rst) begin
        rr_m[j] = 0;
        q_m[j].delete();
      end else begin
        if (r_valid_master[j] && q_m[j].size() > 0) void'(q_m[j].pop_front());
        if (exp_req[j] && gnt_master[j]) begin
          q_m[j].push_back(exp_win[j]);
          rr_m[j] = (exp_win[j] + 1) % NREQ;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_slave      = '0;
    add_slave      = '0;
    wen_slave      = '0;
    wdata_slave    = '0;
    be_slave       = '0;
    gnt_master     = '0;
    r_valid_master = '0;
    r_rdata_master = '0;
  endtask

  task automatic drain();
    bit pend;
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      r_valid_master = '0;
      pend = 1'b0;
      for (int j = 0; j < NPX; j++) if (q_m[j].size() > 0) pend = 1'b1;
      if (!pend) return;
      for (int j = 0; j < NPX; j++) r_valid_master[j] = (q_m[j].size() > 0);
      #2; model_eval();
      checks++;
      if (r_valid_slave !== exp_rv) begin
        errors++;
        $display("FAIL drain_rvalid: got %b want %b", r_valid_slave, exp_rv);
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: outstanding responses still pending after 20 cycles");
  endtask

  task automatic test_reset();
    idle_inputs();
    rst            = 1'b1;
    req_slave      = '1;
    gnt_master     = '1;
    r_valid_master = '1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (req_master !== '0 || gnt_slave !== '0 || r_valid_slave !== '0) begin
        errors++;
        $display("FAIL reset_outputs: req %b gnt %b rv %b want all 0",
                 req_master, gnt_slave, r_valid_slave);
      end
      tick();
    end
    rst            = 1'b0;
    r_valid_master = '0;
    gnt_master     = 4'b0001;
    #2; model_eval();
    checks++;
    if (gnt_slave[0][0] !== 1'b1 || gnt_slave[1][0] !== 1'b0 || req_master !== 4'b1111) begin
      errors++;
      $display("FAIL reset_first_grant: gnt %b req %b want gnt[0][0]=1 req 1111",
               gnt_slave, req_master);
    end
    tick();
    drain();
  endtask

  task automatic test_round_robin();
    int rr0;
    int exp_g;
    idle_inputs();
    rr0             = rr_m[0];
    req_slave[0][0] = 1'b1;
    req_slave[1][0] = 1'b1;
    gnt_master[0]   = 1'b1;
    for (int n = 0; n < 8; n++) begin
      r_valid_master[0] = (q_m[0].size() > 0);
      #2; model_eval();
      exp_g = (rr0 + n) % NREQ;
      checks++;
      if (gnt_slave[exp_g][0] !== 1'b1 || gnt_slave[1 - exp_g][0] !== 1'b0) begin
        errors++;
        $display("FAIL rr_alternate: cycle %0d gnt %b want requester %0d", n, gnt_slave, exp_g);
      end
      checks++;
      if (r_valid_slave !== exp_rv) begin
        errors++;
        $display("FAIL rr_rvalid_owner: cycle %0d got %b want %b", n, r_valid_slave, exp_rv);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    idle_inputs();
    req_slave[1][2] = 1'b1;
    wen_slave[1][2] = 1'b1;
    gnt_master[2]   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (req_master[2] !== 1'b1 || gnt_slave[1][2] !== 1'b1) begin
        errors++;
        $display("FAIL full_fill: cycle %0d req %b gnt %b want req[2]=1 gnt[1][2]=1",
                 c, req_master, gnt_slave);
      end
      tick();
    end
    #2;
    checks++;
    if (req_master[2] !== 1'b0 || gnt_slave[1][2] !== 1'b0) begin
      errors++;
      $display("FAIL full_block: req %b gnt %b want req[2]=0", req_master, gnt_slave);
    end
    tick();
    r_valid_master[2] = 1'b1;
    #2;
    checks++;
    if (req_master[2] !== 1'b0 || r_valid_slave[1][2] !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_no_unblock: req %b rv %b want req[2]=0 rv[1][2]=1",
               req_master, r_valid_slave);
    end
    tick();
    r_valid_master[2] = 1'b0;
    #2;
    checks++;
    if (req_master[2] !== 1'b1 || gnt_slave[1][2] !== 1'b1) begin
      errors++;
      $display("FAIL full_unblock_next: req %b gnt %b want req[2]=1", req_master, gnt_slave);
    end
    tick();
    drain();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    req_slave[0][2] = 1'b1;
    gnt_master[2]   = 1'b1;
    #2;
    checks++;
    if (gnt_slave[0][2] !== 1'b1) begin
      errors++;
      $display("FAIL same_setup: gnt %b want gnt[0][2]=1", gnt_slave);
    end
    tick();
    req_slave[0][2]   = 1'b0;
    req_slave[1][2]   = 1'b1;
    r_valid_master[2] = 1'b1;
    #2;
    checks++;
    if (gnt_slave[1][2] !== 1'b1 || r_valid_slave[0][2] !== 1'b1 || r_valid_slave[1][2] !== 1'b0) begin
      errors++;
      $display("FAIL same_push_pop: gnt %b rv %b want gnt[1][2]=1 rv[0][2]=1",
               gnt_slave, r_valid_slave);
    end
    tick();
    req_slave = '0;
    #2;
    checks++;
    if (r_valid_slave[1][2] !== 1'b1 || r_valid_slave[0][2] !== 1'b0) begin
      errors++;
      $display("FAIL same_next_owner: rv %b want rv[1][2]=1", r_valid_slave);
    end
    tick();
    drain();
  endtask

  task automatic test_ports_data();
    logic [NREQ-1:0][NPX-1:0] e;
    logic [WW-1:0] wd;
    logic [WW-1:0] rd;
    wd = 64'hA5A5_0001_DEAD_BEEF;
    rd = 64'h1234_5678_9ABC_DEF0;
    idle_inputs();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < NPX; j++) begin
        add_slave[i][j]   = $urandom;
        wen_slave[i][j]   = 1'($urandom);
        wdata_slave[i][j] = {$urandom, $urandom};
        be_slave[i][j]    = 8'($urandom);
      end
    wdata_slave[1][0] = wd;
    wdata_slave[0][3] = wd;
    req_slave[1][0]   = 1'b1;
    req_slave[0][3]   = 1'b1;
    gnt_master        = 4'b1001;
    e       = '0;
    e[1][0] = 1'b1;
    e[0][3] = 1'b1;
    #2;
    checks++;
    if (gnt_slave !== e || req_master !== 4'b1001) begin
      errors++;
      $display("FAIL ports_grant: gnt %b req %b want gnt %b req 1001", gnt_slave, req_master, e);
    end
    checks++;
    if (add_master[0] !== add_slave[1][0] || wen_master[0] !== wen_slave[1][0] ||
        wdata_master[0] !== wd || be_master[0] !== be_slave[1][0]) begin
      errors++;
      $display("FAIL ports_mux0: add %h wdata %h be %h want add %h wdata %h be %h",
               add_master[0], wdata_master[0], be_master[0], add_slave[1][0], wd, be_slave[1][0]);
    end
    checks++;
    if (add_master[3] !== add_slave[0][3] || wen_master[3] !== wen_slave[0][3] ||
        wdata_master[3] !== wd || be_master[3] !== be_slave[0][3]) begin
      errors++;
      $display("FAIL ports_mux3: add %h wdata %h be %h want add %h wdata %h be %h",
               add_master[3], wdata_master[3], be_master[3], add_slave[0][3], wd, be_slave[0][3]);
    end
    tick();
    req_slave         = '0;
    gnt_master        = '0;
    r_valid_master    = 4'b1001;
    r_rdata_master[1] = {$urandom, $urandom};
    r_rdata_master[2] = {$urandom, $urandom};
    r_rdata_master[0] = rd;
    r_rdata_master[3] = rd;
    #2;
    checks++;
    if (r_valid_slave !== e) begin
      errors++;
      $display("FAIL ports_rvalid: got %b want %b", r_valid_slave, e);
    end
    checks++;
    if (r_rdata_slave[0][0] !== rd || r_rdata_slave[1][0] !== rd ||
        r_rdata_slave[0][3] !== rd || r_rdata_slave[1][3] !== rd) begin
      errors++;
      $display("FAIL ports_rdata: got %h %h %h %h want %h", r_rdata_slave[0][0],
               r_rdata_slave[1][0], r_rdata_slave[0][3], r_rdata_slave[1][3], rd);
    end
    tick();
    drain();
  endtask

  task automatic test_spurious();
    idle_inputs();
    r_valid_master = '1;
    #2;
    checks++;
    if (r_valid_slave !== '0) begin
      errors++;
      $display("FAIL spurious_rvalid: got %b want 0", r_valid_slave);
    end
    tick();
    r_valid_master  = '0;
    req_slave[0][1] = 1'b1;
    gnt_master[1]   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (req_master[1] !== (c < 2)) begin
        errors++;
        $display("FAIL spurious_count: cycle %0d req[1] %b want %b", c, req_master[1], (c < 2));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < NPX; j++) begin
          req_slave[i][j]   = 1'($urandom);
          wen_slave[i][j]   = 1'($urandom);
          add_slave[i][j]   = $urandom;
          wdata_slave[i][j] = {$urandom, $urandom};
          be_slave[i][j]    = 8'($urandom);
        end
      for (int j = 0; j < NPX; j++) begin
        gnt_master[j]     = ($urandom_range(0, 3) != 0);
        r_valid_master[j] = (q_m[j].size() > 0) ? 1'($urandom) : 1'b0;
        r_rdata_master[j] = {$urandom, $urandom};
      end
      #2; model_eval();
      checks++;
      if (req_master !== exp_req || gnt_slave !== exp_gnt || r_valid_slave !== exp_rv) begin
        errors++;
        $display("FAIL rnd_ctrl: cycle %0d req %b/%b gnt %b/%b rv %b/%b (got/want)", n,
                 req_master, exp_req, gnt_slave, exp_gnt, r_valid_slave, exp_rv);
      end
      for (int j = 0; j < NPX; j++) begin
        if (exp_win[j] >= 0) begin
          checks++;
          if (add_master[j] !== add_slave[exp_win[j]][j] || wen_master[j] !== wen_slave[exp_win[j]][j] ||
              wdata_master[j] !== wdata_slave[exp_win[j]][j] || be_master[j] !== be_slave[exp_win[j]][j]) begin
            errors++;
            $display("FAIL rnd_mux: cycle %0d port %0d add %h want %h wdata %h want %h", n, j,
                     add_master[j], add_slave[exp_win[j]][j], wdata_master[j], wdata_slave[exp_win[j]][j]);
          end
        end
        checks++;
        if (r_rdata_slave[0][j] !== r_rdata_master[j] || r_rdata_slave[1][j] !== r_rdata_master[j]) begin
          errors++;
          $display("FAIL rnd_rdata: cycle %0d port %0d got %h %h want %h", n, j,
                   r_rdata_slave[0][j], r_rdata_slave[1][j], r_rdata_master[j]);
        end
      end
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_full();
    test_same_cycle();
    test_ports_data();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tcdm_g_arbiter.md
Name: tcdm_g_arbiter

Overview:
- Shares one grouped TCDM master interface (NPX ports, each SIZE*DATA_WIDTH wide) between NREQ grouped requesters, e.g. HWCE load engine, store engine and DMA.
- Sits between the requesters and the grouped-bus splitter that fans each wide port out to the TCDM banks.
- Each port j has its own round-robin arbiter and an in-order response-routing FIFO that returns r_valid/rdata to the requester that issued the request.

Parameters:
- ADDR_WIDTH, 32, address width per port
- DATA_WIDTH, 32, data width of one lane
- BE_WIDTH, DATA_WIDTH/8, byte enables per lane
- SIZE, 1, lanes bundled per port; wide data = SIZE*DATA_WIDTH
- NPX, 4, number of independent grouped ports
- NREQ, 2, number of requesters (>=2)
- MAX_OUTST, 2, per-port outstanding-request depth (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_slave  in  [NREQ][NPX]  request per requester/port
- add_slave  in  [NREQ][NPX][ADDR_WIDTH]  address
- wen_slave  in  [NREQ][NPX]  1=load, 0=store
- wdata_slave  in  [NREQ][NPX][SIZE*DATA_WIDTH]  write data
- be_slave  in  [NREQ][NPX][SIZE*BE_WIDTH]  byte enables
- gnt_slave  out  [NREQ][NPX]  grant
- r_valid_slave  out  [NREQ][NPX]  response valid
- r_rdata_slave  out  [NREQ][NPX][SIZE*DATA_WIDTH]  response data
- req_master  out  [NPX]  request to TCDM
- add_master  out  [NPX][ADDR_WIDTH]  address
- wen_master  out  [NPX]  load/store
- wdata_master  out  [NPX][SIZE*DATA_WIDTH]  write data
- be_master  out  [NPX][SIZE*BE_WIDTH]  byte enables
- gnt_master  in  [NPX]  TCDM grant
- r_valid_master  in  [NPX]  TCDM response valid (in order, >=1 cycle after handshake)
- r_rdata_master  in  [NPX][SIZE*DATA_WIDTH]  TCDM response data

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Ports are fully independent; everything below applies per port j.

State per port:
- rr_ptr (clog2(NREQ) bits).
- Owner FIFO: MAX_OUTST entries of requester IDs, with wr_ptr, rd_ptr and count.
- Reset: rr_ptr=0, count=0, pointers=0.
- While rst=1, all outputs req_master, gnt_slave and r_valid_slave are forced 0.

Arbitration (combinational):
- winner = first i with req_slave[i][j]=1, scanning from rr_ptr upward modulo NREQ.
- full = (count==MAX_OUTST), taken from the registered count.
- A pop in the same cycle does NOT unblock a push.
- req_master[j] = |req_slave[*][j] & ~full.
- add/wen/wdata/be master = winner's fields; when no winner they are don't-care and drive requester 0's fields.
- gnt_slave[winner][j] = gnt_master[j] & req_master[j]; all other grants are 0. Zero-cycle grant path.
- Handshake hs = req_master[j] & gnt_master[j].
- On hs: push winner ID; rr_ptr <= (winner+1) mod NREQ. Without hs, rr_ptr holds.
- The winner may change between cycles while ungranted; TCDM allows req/addr changes before grant.

Response routing:
- On r_valid_master[j]=1: r_valid_slave[head][j]=1, others 0; pop.
- r_rdata_slave[i][j] = r_rdata_master[j] for all i (broadcast; qualified by r_valid).
- Response in the same cycle as hs is allowed: push and pop together, count unchanged.
- r_valid_master with count==0 is a protocol error: no output, count stays 0 (no underflow). Simulation assertion flags it.
- Stores also return r_valid and are routed the same way.

Decomposition:
- Package tcdm_g_pkg holds:
  - localparam function for ID_W = (NREQ>1) ? clog2(NREQ) : 1.
  - typedef of the owner-ID type.
  - Shared assertion macro for protocol errors.
- Sub-module tcdm_g_rr_port: one port's arbiter, rr_ptr and owner FIFO; instantiated NPX times by a generate loop.

Test Plan:
1. Reset then idle (NREQ=2, NPX=4, MAX_OUTST=2): rst=1 for 3 cycles with req_slave all 1 -> req_master, gnt_slave and r_valid_slave all 0. After release, port 0 grants requester 0 first.
2. Round-robin fairness: requesters 0 and 1 both request continuously on port 0, gnt_master=1, r_valid one cycle after each hs -> grants alternate 0,1,0,1 for 8 cycles, and each r_valid returns to the matching owner.
3. FIFO full back-pressure: requester 1 issues 2 loads on port 2 with no r_valid -> third cycle req_master[2]=0. Assert r_valid once -> req_master[2] rises the following cycle, not the same cycle.
4. Same-cycle push/pop: count=1 (owner 0). Requester 1 handshakes while r_valid_master=1 -> r_valid_slave[0][2]=1, count stays 1, next response goes to requester 1.
5. Port independence and data path (SIZE=2): different requesters on ports 0 and 3 simultaneously with wdata=0xA5A5_0001_DEAD_BEEF -> correct per-port mux; r_rdata 0x1234_5678_9ABC_DEF0 is seen by all requesters but r_valid only to the owner.
6. Spurious r_valid with count=0 -> no r_valid_slave, count stays 0, assertion fires.
